// File: rtl/dm_pkg.sv
// Debug-module shared types: the DMI request/response payloads exchanged
// between the DTM, its requesters and the DMI clock-domain crossing.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_arb_tag_fifo.sv
// In-order FIFO of requester tags, one entry per accepted-but-unanswered
// DMI request. Push is ignored when full, pop is ignored when empty.
module dmi_arb_tag_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read while
    // count_q says it holds a pushed tag, so reset would only cost flops.
    always_ff @(posedge tck_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dmi_req_arbiter.sv
// Round-robin arbiter sharing one DMI request/response channel between two
// TCK-domain requesters; responses are routed back via an in-order tag FIFO.
module dmi_req_arbiter #(
    parameter int unsigned NumOutstanding = 2
) (
    input  logic         tck_i,
    input  logic         trst_ni,
    input  dm::dmi_req_t req0_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  dm::dmi_req_t req1_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    output dm::dmi_resp_t resp0_o,
    output logic         resp0_valid_o,
    input  logic         resp0_ready_i,
    output dm::dmi_resp_t resp1_o,
    output logic         resp1_valid_o,
    input  logic         resp1_ready_i,
    output dm::dmi_req_t dmi_req_o,
    output logic         dmi_req_valid_o,
    input  logic         dmi_req_ready_i,
    input  dm::dmi_resp_t dmi_resp_i,
    input  logic         dmi_resp_valid_i,
    output logic         dmi_resp_ready_o,
    output logic         busy_o,
    output logic         resp_drop_o
);

    logic prio_q, prio_d;
    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic resp_drop_q;
    logic grant, grant_valid, accept;
    logic full, empty, head, pop;

    // A held grant keeps dmi_req_o stable while downstream back-pressures.
    always_comb begin
        if (lock_q)                             grant = lock_id_q;
        else if (req0_valid_i && req1_valid_i)  grant = prio_q;
        else                                    grant = req1_valid_i;
    end

    assign grant_valid     = grant ? req1_valid_i : req0_valid_i;
    assign dmi_req_o       = grant ? req1_i : req0_i;
    assign dmi_req_valid_o = grant_valid && !full;
    assign req0_ready_o    = !grant && dmi_req_ready_i && !full;
    assign req1_ready_o    =  grant && dmi_req_ready_i && !full;
    assign accept          = dmi_req_valid_o && dmi_req_ready_i;

    always_comb begin
        prio_d    = prio_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            prio_d = ~grant;
            lock_d = 1'b0;
        end else if (grant_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end else begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            prio_q      <= 1'b0;
            lock_q      <= 1'b0;
            lock_id_q   <= 1'b0;
            resp_drop_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
            resp_drop_q <= dmi_resp_valid_i && empty;
        end
    end

    dmi_arb_tag_fifo #(
        .Depth (NumOutstanding),
        .Width (1)
    ) i_tag_fifo (
        .tck_i   (tck_i),
        .trst_ni (trst_ni),
        .push_i  (accept),
        .data_i  (grant),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // With nothing outstanding, responses are sunk so the CDC never stalls.
    assign dmi_resp_ready_o = empty || (head ? resp1_ready_i : resp0_ready_i);
    assign resp0_valid_o    = dmi_resp_valid_i && !empty && !head;
    assign resp1_valid_o    = dmi_resp_valid_i && !empty &&  head;
    assign resp0_o          = dmi_resp_i;
    assign resp1_o          = dmi_resp_i;
    assign pop              = dmi_resp_valid_i && !empty && dmi_resp_ready_o;
    assign busy_o           = !empty;
    assign resp_drop_o      = resp_drop_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed self-checking bench for dmi_req_arbiter: inputs change on the
// falling edge, outputs are sampled 1ns later, state commits on the rising edge.
module tb_dmi_req_arbiter;

    logic          tck_i = 1'b0;
    logic          trst_ni;
    dm::dmi_req_t  req0_i, req1_i, dmi_req_o;
    logic          req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    dm::dmi_resp_t resp0_o, resp1_o, dmi_resp_i;
    logic          resp0_valid_o, resp1_valid_o, resp0_ready_i, resp1_ready_i;
    logic          dmi_req_valid_o, dmi_req_ready_i;
    logic          dmi_resp_valid_i, dmi_resp_ready_o;
    logic          busy_o, resp_drop_o;

    int tests = 0;
    int fails = 0;

    always #5 tck_i = ~tck_i;

    dmi_req_arbiter #(.NumOutstanding(2)) dut (
        .tck_i            (tck_i),
        .trst_ni          (trst_ni),
        .req0_i           (req0_i),
        .req0_valid_i     (req0_valid_i),
        .req0_ready_o     (req0_ready_o),
        .req1_i           (req1_i),
        .req1_valid_i     (req1_valid_i),
        .req1_ready_o     (req1_ready_o),
        .resp0_o          (resp0_o),
        .resp0_valid_o    (resp0_valid_o),
        .resp0_ready_i    (resp0_ready_i),
        .resp1_o          (resp1_o),
        .resp1_valid_o    (resp1_valid_o),
        .resp1_ready_i    (resp1_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_resp_i       (dmi_resp_i),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .busy_o           (busy_o),
        .resp_drop_o      (resp_drop_o)
    );

    function automatic dm::dmi_req_t mk_req(input logic [6:0] addr, input logic [31:0] data);
        dm::dmi_req_t r;
        r.addr = addr;
        r.op   = dm::DTM_READ;
        r.data = data;
        return r;
    endfunction

    task automatic idle_inputs();
        req0_valid_i     = 1'b0;
        req1_valid_i     = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        resp0_ready_i    = 1'b1;
        resp1_ready_i    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge tck_i);
        trst_ni = 1'b0;
        idle_inputs();
        @(negedge tck_i);
        trst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge tck_i);
        #1;
        tests++;
        if ({dmi_req_valid_o, req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o} !== 5'b0) begin
            fails++;
            $display("FAIL reset_valids: got %b required 00000",
                     {dmi_req_valid_o, req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o});
        end
        tests++;
        if ({dmi_resp_ready_o, busy_o, resp_drop_o} !== 3'b100) begin
            fails++;
            $display("FAIL reset_status: got %b required 100", {dmi_resp_ready_o, busy_o, resp_drop_o});
        end
    endtask

    task automatic test_single();
        trst_ni         = 1'b1;
        req0_i          = mk_req(7'h11, 32'h0);
        req0_valid_i    = 1'b1;
        dmi_req_ready_i = 1'b1;
        #1;
        tests++;
        if ({dmi_req_o.addr, dmi_req_valid_o, req0_ready_o, req1_ready_o} !== {7'h11, 3'b110}) begin
            fails++;
            $display("FAIL single_req: got addr=%h v/r0/r1=%b required addr=11 v/r0/r1=110",
                     dmi_req_o.addr, {dmi_req_valid_o, req0_ready_o, req1_ready_o});
        end
        @(negedge tck_i);
        idle_inputs();
        #1;
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL single_busy: got %b required 1", busy_o);
        end
        @(negedge tck_i);
        dmi_resp_i       = '{data: 32'hDEADBEEF, resp: 2'b00};
        dmi_resp_valid_i = 1'b1;
        #1;
        tests++;
        if ({resp0_valid_o, resp1_valid_o, dmi_resp_ready_o} !== 3'b101 || resp0_o.data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_resp: got v0/v1/rdy=%b data=%h required 101 data=deadbeef",
                     {resp0_valid_o, resp1_valid_o, dmi_resp_ready_o}, resp0_o.data);
        end
        @(negedge tck_i);
        dmi_resp_valid_i = 1'b0;
        #1;
        tests++;
        if ({busy_o, resp_drop_o} !== 2'b00) begin
            fails++;
            $display("FAIL single_pop: got busy/drop=%b required 00", {busy_o, resp_drop_o});
        end
    endtask

    // Responses overlap the requests so the 2-deep tag FIFO never fills.
    task automatic test_back_to_back();
        logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
        logic [1:0] exp_rsp [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
        do_reset();
        req0_i = mk_req(7'h01, 32'h0);
        req1_i = mk_req(7'h02, 32'h0);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge tck_i);
            req0_valid_i     = (c < 3);
            req1_valid_i     = (c < 3);
            dmi_req_ready_i  = (c < 3);
            dmi_resp_valid_i = (c >= 1);
            dmi_resp_i       = '{data: 32'h100 + c, resp: 2'b00};
            #1;
            tests++;
            if ({req1_ready_o, req0_ready_o} !== exp_rdy[c]) begin
                fails++;
                $display("FAIL b2b_grant[%0d]: got r1r0=%b required %b", c, {req1_ready_o, req0_ready_o}, exp_rdy[c]);
            end
            tests++;
            if ({resp1_valid_o, resp0_valid_o} !== exp_rsp[c]) begin
                fails++;
                $display("FAIL b2b_route[%0d]: got v1v0=%b required %b", c, {resp1_valid_o, resp0_valid_o}, exp_rsp[c]);
            end
        end
        @(negedge tck_i);
        idle_inputs();
    endtask

    // Entered with priority on requester 1, so only the lock keeps req0 granted.
    task automatic test_hold();
        req0_i = mk_req(7'h22, 32'hA5A5_0000);
        req1_i = mk_req(7'h33, 32'h5A5A_0000);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge tck_i);
            req0_valid_i    = (c < 4);
            req1_valid_i    = (c >= 1);
            dmi_req_ready_i = (c >= 3);
            #1;
            tests++;
            if (c < 4 && ({dmi_req_o.addr, dmi_req_valid_o, req1_ready_o, req0_ready_o} !== {7'h22, 1'b1, 1'b0, c == 3})) begin
                fails++;
                $display("FAIL hold[%0d]: got addr=%h v/r1/r0=%b required addr=22 v/r1/r0=10%b",
                         c, dmi_req_o.addr, {dmi_req_valid_o, req1_ready_o, req0_ready_o}, c == 3);
            end else if (c == 4 && ({dmi_req_o.addr, req1_ready_o, req0_ready_o} !== {7'h33, 2'b10})) begin
                fails++;
                $display("FAIL hold_next: got addr=%h r1r0=%b required addr=33 r1r0=10",
                         dmi_req_o.addr, {req1_ready_o, req0_ready_o});
            end
        end
        @(negedge tck_i);
        idle_inputs();
        dmi_resp_valid_i = 1'b1;
        #1;
        tests++;
        if ({resp1_valid_o, resp0_valid_o} !== 2'b01) begin
            fails++;
            $display("FAIL hold_resp0: got v1v0=%b required 01", {resp1_valid_o, resp0_valid_o});
        end
        @(negedge tck_i);
        #1;
        tests++;
        if ({resp1_valid_o, resp0_valid_o} !== 2'b10) begin
            fails++;
            $display("FAIL hold_resp1: got v1v0=%b required 10", {resp1_valid_o, resp0_valid_o});
        end
        @(negedge tck_i);
        dmi_resp_valid_i = 1'b0;
        #1;
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_idle: got busy=%b required 0", busy_o);
        end
    endtask

    // Full is taken from the registered count, so a pop does not unblock the same cycle.
    task automatic test_full();
        logic [4:0] exp_v = 5'b10011;
        req0_i = mk_req(7'h44, 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge tck_i);
            req0_valid_i     = 1'b1;
            dmi_req_ready_i  = 1'b1;
            dmi_resp_valid_i = (c == 3);
            #1;
            tests++;
            if ({dmi_req_valid_o, req0_ready_o} !== {2{exp_v[c]}}) begin
                fails++;
                $display("FAIL full[%0d]: got valid/r0=%b required %b", c, {dmi_req_valid_o, req0_ready_o}, {2{exp_v[c]}});
            end
            if (c == 3) begin
                tests++;
                if (resp0_valid_o !== 1'b1) begin
                    fails++;
                    $display("FAIL full_pop: got resp0_valid=%b required 1", resp0_valid_o);
                end
            end
        end
        @(negedge tck_i);
        idle_inputs();
        dmi_resp_valid_i = 1'b1;
        @(negedge tck_i);
        @(negedge tck_i);
        dmi_resp_valid_i = 1'b0;
        #1;
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL full_drain: got busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_drop();
        @(negedge tck_i);
        dmi_resp_valid_i = 1'b1;
        resp0_ready_i    = 1'b0;
        resp1_ready_i    = 1'b0;
        #1;
        tests++;
        if ({dmi_resp_ready_o, resp0_valid_o, resp1_valid_o, resp_drop_o} !== 4'b1000) begin
            fails++;
            $display("FAIL drop_accept: got rdy/v0/v1/drop=%b required 1000",
                     {dmi_resp_ready_o, resp0_valid_o, resp1_valid_o, resp_drop_o});
        end
        @(negedge tck_i);
        idle_inputs();
        #1;
        tests++;
        if (resp_drop_o !== 1'b1) begin
            fails++;
            $display("FAIL drop_pulse: got %b required 1", resp_drop_o);
        end
        @(negedge tck_i);
        #1;
        tests++;
        if (resp_drop_o !== 1'b0) begin
            fails++;
            $display("FAIL drop_width: got %b required 0", resp_drop_o);
        end
    endtask

    // Last accept before reset is req0, so priority would sit on req1 without reset.
    task automatic test_reset_mid();
        req0_i = mk_req(7'h55, 32'h0);
        req1_i = mk_req(7'h66, 32'h0);
        @(negedge tck_i);
        req0_valid_i    = 1'b1;
        dmi_req_ready_i = 1'b1;
        @(negedge tck_i);
        @(negedge tck_i);
        idle_inputs();
        #1;
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_busy_pre: got %b required 1", busy_o);
        end
        trst_ni = 1'b0;
        #1;
        tests++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_busy_async: got %b required 0", busy_o);
        end
        @(negedge tck_i);
        trst_ni      = 1'b1;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        #1;
        tests++;
        if (dmi_req_o.addr !== 7'h55) begin
            fails++;
            $display("FAIL rst_prio: got addr=%h required 55", dmi_req_o.addr);
        end
        @(negedge tck_i);
        idle_inputs();
        dmi_resp_valid_i = 1'b1;
        #1;
        tests++;
        if ({dmi_resp_ready_o, resp0_valid_o, resp1_valid_o} !== 3'b100) begin
            fails++;
            $display("FAIL rst_resp_drop: got rdy/v0/v1=%b required 100",
                     {dmi_resp_ready_o, resp0_valid_o, resp1_valid_o});
        end
        @(negedge tck_i);
        dmi_resp_valid_i = 1'b0;
        req1_valid_i     = 1'b1;
        dmi_req_ready_i  = 1'b1;
        #1;
        tests++;
        if ({resp_drop_o, dmi_req_o.addr, req1_ready_o, req0_ready_o} !== {1'b1, 7'h66, 2'b10}) begin
            fails++;
            $display("FAIL rst_req1: got drop=%b addr=%h r1r0=%b required drop=1 addr=66 r1r0=10",
                     resp_drop_o, dmi_req_o.addr, {req1_ready_o, req0_ready_o});
        end
        @(negedge tck_i);
        idle_inputs();
        #1;
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_req1_busy: got %b required 1", busy_o);
        end
    endtask

    initial begin
        trst_ni    = 1'b0;
        req0_i     = '0;
        req1_i     = '0;
        dmi_resp_i = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_full();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmi_req_arbiter.md
# dmi_req_arbiter

Two-requester arbiter sharing a single DMI request/response channel in the TCK domain. It sits between two DMI masters (the JTAG DTM FSM and a second TCK-domain requester such as a scripted debug sequencer) and the downstream DMI CDC. It applies round-robin arbitration and holds a granted request stable until it is accepted. It tracks the originator of every outstanding request in an in-order tag FIFO and routes each response back to the requester that issued it.

## Interface
- NumOutstanding, 2: maximum accepted-but-unanswered requests; power of two, ≥1.
- tck_i  in  1  JTAG test clock; all logic on rising edge.
- trst_ni  in  1  reset, asynchronous, active-low.
- req0_i / req1_i  in  dm::dmi_req_t  request from requester 0 / 1.
- req0_valid_i / req1_valid_i  in  1  request valid.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle.
- resp0_o / resp1_o  out  dm::dmi_resp_t  response to requester 0 / 1.
- resp0_valid_o / resp1_valid_o  out  1  response valid.
- resp0_ready_i / resp1_ready_i  in  1  requester takes response.
- dmi_req_o  out  dm::dmi_req_t  request to CDC.
- dmi_req_valid_o  out  1  downstream request valid.
- dmi_req_ready_i  in  1  downstream accepts.
- dmi_resp_i  in  dm::dmi_resp_t  response from CDC.
- dmi_resp_valid_i  in  1  downstream response valid.
- dmi_resp_ready_o  out  1  arbiter takes response.
- busy_o  out  1  at least one request outstanding.
- resp_drop_o  out  1  one-cycle pulse: response received with nothing outstanding.

## Operation
- State: prio_q (1 bit, requester with priority), lock_q/lock_id_q (grant held), tag FIFO of requester IDs with count_q of width $clog2(NumOutstanding+1).
- Grant selection when not locked:
  - Both valid → grant prio_q.
  - One valid → grant that one.
  - None valid → no grant.
- When locked, grant = lock_id_q regardless of other valids.
- full = (count_q == NumOutstanding).
- dmi_req_valid_o = granted requester valid && !full.
- dmi_req_o = granted req, combinational mux; zero-cycle latency.
- reqN_ready_o = (grant==N) && dmi_req_ready_i && !full; ungranted requester always sees 0.
- Accept (dmi_req_valid_o && dmi_req_ready_i):
  - Push grant ID into the FIFO.
  - prio_d = ~grant.
  - Clear lock.
- Valid presented but not accepted: set lock_q and lock_id_q = grant. dmi_req_o stays stable until acceptance.
- Requester dropping valid while locked is a protocol violation; lock clears when that valid is low.
- Response routing, strictly in order:
  - Head ID h selects the target.
  - resph_valid_o = dmi_resp_valid_i && !empty.
  - resph_o = dmi_resp_i.
  - dmi_resp_ready_o = resph_ready_i.
  - Pop on handshake.
- Empty FIFO: dmi_resp_ready_o = 1; a valid response is consumed, no respN_valid_o is raised, and resp_drop_o pulses.
- Full and a pop in the same cycle: request stays blocked this cycle (full is evaluated from count_q); accept possible next cycle.
- Push and pop in the same cycle: count_q unchanged, FIFO pointers both advance.
- busy_o = (count_q != 0).

## Timing
- Reset values:
  - prio_q=0, lock_q=0, count_q=0.
  - All valid outputs and reqN_ready_o = 0.
  - dmi_resp_ready_o=1, busy_o=0, resp_drop_o=0.
- Request path is combinational (valid→valid, ready→ready); state updates on the accepting edge.
- Response path is combinational; the pop takes effect next edge.
- trst_ni assertion mid-operation discards all outstanding tags. Responses arriving after reset are dropped with a resp_drop_o pulse.
- Maximum throughput: one request and one response per cycle.

## Structure
- dm::dmi_req_t and dm::dmi_resp_t come from the existing dm package. No new package types.
- Sub-module dmi_arb_tag_fifo: parameterised depth and width (width 1 here); push/pop/full/empty/head outputs; reset trst_ni.
- The arbiter top holds the grant/lock/priority logic and the muxes.

## Test plan
1. Only req0 valid, read addr 0x11, dmi_req_ready_i=1 → same-cycle dmi_req_o.addr=0x11, req0_ready_o=1, busy_o=1. Response data 0xDEADBEEF → resp0_valid_o=1, resp1_valid_o=0, busy_o=0 after pop.
2. Both valid from reset, ready=1 → req0 accepted cycle 0, req1 cycle 1, req0 cycle 2 (alternation). Responses return to 0,1,0 in order.
3. req0 valid, ready=0 for 3 cycles, req1 raised in cycle 1 → dmi_req_o holds req0 contents all 4 cycles. req0 accepted on cycle 3; req1 accepted next.
4. NumOutstanding=2, three back-to-back requests, no responses → third held, dmi_req_valid_o=0. One response popped → third accepted the following cycle.
5. dmi_resp_valid_i with FIFO empty → dmi_resp_ready_o=1, no respN_valid_o, resp_drop_o pulse of exactly one cycle.
6. Two outstanding, trst_ni low one cycle → busy_o=0, prio_q=0. A subsequent downstream response is dropped; the next req1 is granted normally.
